// File: rtl/generic_pipe_clr.sv
// Valid/ready pipeline of DEPTH register stages with synchronous flush.
// COLLAPSE=1 lets each stage advance independently; COLLAPSE=0 stalls the whole pipe.
module generic_pipe_clr #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               COLLAPSE    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] valid_nxt;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] data_r   [DEPTH];
  logic [WIDTH-1:0] data_nxt [DEPTH];
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt;
  logic             shift;
  logic             in_ready_s;

  // Per-stage advance enables: ripple from the output side, or one global shift.
  always_comb begin : adv_calc
    logic carry;
    shift = !(valid_r[DEPTH-1] && !out_ready);
    carry = out_ready;
    adv   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (COLLAPSE != 0) begin
        adv[i] = carry;
        carry  = !valid_r[i] || carry;
      end else begin
        adv[i] = shift;
      end
    end
    if (COLLAPSE != 0) begin
      in_ready_s = (!valid_r[0] || adv[0]) && !clr;
    end else begin
      in_ready_s = shift && !clr;
    end
  end

  // Next stage contents; data registers only load when a valid item arrives.
  always_comb begin
    valid_nxt = valid_r;
    data_nxt  = data_r;
    if (clr) begin
      valid_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_nxt[i] = RESET_VALUE;
      end
    end else begin
      if (in_ready_s) begin
        valid_nxt[0] = in_valid;
        if (in_valid) begin
          data_nxt[0] = in_data;
        end else begin
          data_nxt[0] = data_r[0];
        end
      end else if (adv[0]) begin
        valid_nxt[0] = 1'b0;
      end else begin
        valid_nxt[0] = valid_r[0];
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i-1]) begin
          valid_nxt[i] = valid_r[i-1];
          if (valid_r[i-1]) begin
            data_nxt[i] = data_r[i-1];
          end else begin
            data_nxt[i] = data_r[i];
          end
        end else if (adv[i]) begin
          valid_nxt[i] = 1'b0;
        end else begin
          valid_nxt[i] = valid_r[i];
        end
      end
    end
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_nxt = count_nxt + CW'(valid_nxt[i]);
    end
  end

  // Stage registers and registered occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= RESET_VALUE;
      end
    end else begin
      valid_r <= valid_nxt;
      count_r <= count_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= data_nxt[i];
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_r[DEPTH-1];
  assign out_data  = data_r[DEPTH-1];
  assign count     = count_r;

endmodule

// File: tb/tb_generic_pipe_clr.sv
// Directed bench for generic_pipe_clr: both COLLAPSE variants driven in parallel,
// checked every cycle against queue-based models plus literal expectations.
module tb_generic_pipe_clr;

  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'h5A;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, out_ready;
  logic [7:0] in_data;
  logic       d1_in_ready, d1_out_valid, d0_in_ready, d0_out_valid;
  logic [7:0] d1_out_data, d0_out_data;
  logic [1:0] d1_count, d0_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  generic_pipe_clr #(.WIDTH(8), .DEPTH(D), .RESET_VALUE(RV), .COLLAPSE(1)) d1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(d1_in_ready), .out_valid(d1_out_valid), .out_data(d1_out_data),
    .out_ready(out_ready), .count(d1_count));

  generic_pipe_clr #(.WIDTH(8), .DEPTH(D), .RESET_VALUE(RV), .COLLAPSE(0)) d0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(d0_in_ready), .out_valid(d0_out_valid), .out_data(d0_out_data),
    .out_ready(out_ready), .count(d0_count));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Collapsing model: oldest-first list of items with their stage position.
  int         q1_pos[$];
  logic [7:0] q1_dat[$];
  logic [7:0] m1_out;
  int         m1_np[D];
  bit         m1_pop;
  bit         m1_free0;

  function void m1_plan();
    int limit;
    limit    = D;
    m1_pop   = 1'b0;
    m1_free0 = 1'b1;
    for (int k = 0; k < q1_pos.size(); k++) begin
      if (k == 0 && q1_pos[0] == D-1 && out_ready) begin
        m1_pop   = 1'b1;
        m1_np[0] = D;
      end else begin
        m1_np[k] = (q1_pos[k] + 1 < limit) ? q1_pos[k] + 1 : q1_pos[k];
        limit    = m1_np[k];
        if (m1_np[k] == 0) m1_free0 = 1'b0;
      end
    end
  endfunction

  task automatic m1_step();
    int         np[$];
    logic [7:0] nd[$];
    if (rst || clr) begin
      q1_pos.delete();
      q1_dat.delete();
      m1_out = RV;
    end else begin
      m1_plan();
      for (int k = 0; k < q1_pos.size(); k++) begin
        if (!(k == 0 && m1_pop)) begin
          np.push_back(m1_np[k]);
          nd.push_back(q1_dat[k]);
          if (m1_np[k] == D-1 && q1_pos[k] != D-1) m1_out = q1_dat[k];
        end
      end
      if (in_valid && m1_free0) begin
        np.push_back(0);
        nd.push_back(in_data);
      end
      q1_pos = np;
      q1_dat = nd;
    end
  endtask

  // Global-stall model: fixed row of slots that all shift together, bubbles included.
  bit         m0_v[$];
  logic [7:0] m0_d[$];
  logic [7:0] m0_out;

  initial begin
    for (int i = 0; i < D; i++) begin
      m0_v.push_back(1'b0);
      m0_d.push_back(8'h00);
    end
  end

  function automatic bit m0_shift();
    return !(m0_v[D-1] && !out_ready);
  endfunction

  function automatic int m0_count();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(m0_v[i]);
    return n;
  endfunction

  task automatic m0_step();
    bit v;
    logic [7:0] dd;
    if (rst || clr) begin
      for (int i = 0; i < D; i++) m0_v[i] = 1'b0;
      m0_out = RV;
    end else if (m0_shift()) begin
      v  = m0_v.pop_back();
      dd = m0_d.pop_back();
      m0_v.push_front(in_valid);
      m0_d.push_front(in_data);
      if (m0_v[D-1]) m0_out = m0_d[D-1];
    end
  endtask

  always @(posedge clk) begin
    m1_step();
    m0_step();
  end

  // Every-cycle comparison of both DUTs against their models.
  always @(negedge clk) begin
    if (chk_en) begin
      m1_plan();
      chk("c1_in_ready", d1_in_ready, m1_free0 && !clr);
      chk("c1_out_valid", d1_out_valid, q1_pos.size() > 0 && q1_pos[0] == D-1);
      chk("c1_out_data", d1_out_data, m1_out);
      chk("c1_count", d1_count, q1_pos.size());
      chk("c0_in_ready", d0_in_ready, m0_shift() && !clr);
      chk("c0_out_valid", d0_out_valid, m0_v[D-1]);
      chk("c0_out_data", d0_out_data, m0_out);
      chk("c0_count", d0_count, m0_count());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit seen;

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", d1_out_valid, 1'b0);
    chk("rst_count", d1_count, 2'd0);
    chk("rst_out_data", d1_out_data, 8'h5A);
    chk("rst_in_ready1", d1_in_ready, 1'b1);
    chk("rst_in_ready0", d0_in_ready, 1'b1);

    // Streaming: three back-to-back items, visible at cycles 3, 4, 5.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h01;
    tick(); in_data = 8'h02;
    tick(); in_data = 8'h03;
    tick(); in_valid = 1'b0;
    chk("stream_v3", d1_out_valid, 1'b1);
    chk("stream_d3", d1_out_data, 8'h01);
    tick();
    chk("stream_d4", d1_out_data, 8'h02);
    tick();
    chk("stream_d5", d1_out_data, 8'h03);
    chk("stream_d5_c0", d0_out_data, 8'h03);
    tick();
    chk("stream_end", d1_out_valid, 1'b0);

    // Backpressure: three accepted, fourth refused, then drain in order.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_data = 8'(k);
      tick();
    end
    in_data = 8'h04;
    #1;
    chk("bp_in_ready", d1_in_ready, 1'b0);
    chk("bp_count", d1_count, 2'd3);
    out_ready = 1'b1;
    #1;
    chk("bp_out1", d1_out_data, 8'h01);
    tick(); in_valid = 1'b0;
    chk("bp_out2", d1_out_data, 8'h02);
    tick();
    chk("bp_out3", d1_out_data, 8'h03);
    tick();
    chk("bp_out4", d1_out_data, 8'h04);
    tick();
    chk("bp_empty", d1_count, 2'd0);

    // Bubble: A, idle, B with the output blocked.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
    tick(); in_valid = 1'b0;
    tick(); in_valid = 1'b1; in_data = 8'hB2;
    tick(); in_valid = 1'b0;
    tick();
    chk("bub_count1", d1_count, 2'd2);
    chk("bub_ready1", d1_in_ready, 1'b1);
    chk("bub_data1", d1_out_data, 8'hA1);
    chk("bub_count0", d0_count, 2'd2);
    chk("bub_ready0", d0_in_ready, 1'b0);
    chk("bub_valid0", d0_out_valid, 1'b1);
    tick();
    chk("bub_frozen0", d0_out_data, 8'hA1);
    out_ready = 1'b1;
    repeat (6) tick();

    // Clear: full pipe, flush while an output transfer happens.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_data = 8'h44; out_ready = 1'b1; clr = 1'b1;
    #1;
    chk("clr_ready1", d1_in_ready, 1'b0);
    chk("clr_ready0", d0_in_ready, 1'b0);
    chk("clr_xfer", d1_out_valid, 1'b1);
    tick(); clr = 1'b0; in_valid = 1'b0;
    chk("clr_count1", d1_count, 2'd0);
    chk("clr_valid1", d1_out_valid, 1'b0);
    chk("clr_data1", d1_out_data, 8'h5A);
    chk("clr_data0", d0_out_data, 8'h5A);

    // Priority: rst with clr mid-stream, then rst alone discards in-flight items.
    in_valid = 1'b1; in_data = 8'h61; tick();
    in_data = 8'h62; tick();
    rst = 1'b1; clr = 1'b1; tick();
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0;
    #1;
    chk("prio_count", d1_count, 2'd0);
    chk("prio_valid", d1_out_valid, 1'b0);
    chk("prio_data", d1_out_data, 8'h5A);
    chk("prio_ready", d1_in_ready, 1'b1);
    in_valid = 1'b1; in_data = 8'h77; tick();
    in_data = 8'h88; tick();
    in_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (d1_out_valid || d0_out_valid) seen = 1'b1;
    end
    chk("rst_discard", seen, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/generic_pipe_clr.md
GENERIC_PIPE_CLR -- requirements
Module: generic_pipe_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, legal range 1 or more.
REQ-002 SHALL have parameter DEPTH, default 2: number of pipeline stages, legal range 1 or more.
REQ-003 SHALL have parameter RESET_VALUE, default 0: data value loaded on reset or clear.
REQ-004 SHALL have parameter COLLAPSE, default 1: 1 = per-stage bubble collapse, 0 = global stall.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port clr, input, 1 bit: synchronous flush of all stages.
REQ-009 SHALL have port in_valid, input, 1 bit: upstream data valid.
REQ-010 SHALL have port in_data, input, WIDTH bits: upstream data.
REQ-011 SHALL have port in_ready, output, 1 bit: stage 0 can accept this cycle.
REQ-012 SHALL have port out_valid, output, 1 bit: last stage holds valid data.
REQ-013 SHALL have port out_data, output, WIDTH bits: last-stage data register.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-015 SHALL have port count, output, $clog2(DEPTH+1) bits: number of valid stages.

Function
REQ-016 SHALL hold a valid bit and a WIDTH-bit data register per stage; stage 0 is the input side, stage DEPTH-1 drives out_valid and out_data.
REQ-017 SHALL define a transfer as valid AND ready at either port in the same cycle.
REQ-018 With COLLAPSE=1, last-stage advance SHALL equal out_ready; stage i (i < DEPTH-1) SHALL advance when stage i+1 is invalid or advancing.
REQ-019 With COLLAPSE=1, in_ready SHALL equal (stage 0 invalid OR stage 0 advancing) AND NOT clr.
REQ-020 With COLLAPSE=0, all stages SHALL shift together unless out_valid AND NOT out_ready; in_ready SHALL equal that shift condition AND NOT clr. Bubbles SHALL be preserved.
REQ-021 An advancing stage SHALL pass its valid bit and data to the next stage; stage 0 SHALL load in_data with valid = in_valid AND in_ready.
REQ-022 A stage's data register SHALL load only when it receives a valid item; otherwise it SHALL hold its value. Only the valid bit clears when an item departs.
REQ-023 Unstalled latency SHALL be exactly DEPTH cycles from input transfer to out_valid; throughput SHALL be one item per cycle; ordering SHALL be FIFO with no loss or duplication.
REQ-024 out_data SHALL be driven directly from the last-stage register, with no combinational path from in_data.
REQ-025 in_ready SHALL NOT depend on in_valid.
REQ-026 count SHALL equal the population count of the stage valid bits after each edge; it SHALL never exceed DEPTH.
REQ-027 Full pipe with out_ready=1 SHALL accept and emit in the same cycle; count SHALL remain unchanged.
REQ-028 clr=1 SHALL, at the next edge, clear all valid bits, load RESET_VALUE into all data registers, and accept no input; the output transfer in that cycle SHALL still count if out_valid AND out_ready.
REQ-029 clr SHALL have priority over in_valid and over all stage advances.

Reset
REQ-030 rst=1 at an edge SHALL clear all valid bits and set all data to RESET_VALUE, giving out_valid=0, count=0, out_data=RESET_VALUE.
REQ-031 rst SHALL take priority over clr and over all transfers.
REQ-032 Items in flight when rst asserts SHALL be discarded.
REQ-033 in_ready SHALL be 1 in the first cycle after rst deasserts, provided clr=0.

Verification
REQ-034 Reset: WIDTH=8, DEPTH=3, RESET_VALUE=0x5A, rst high 2 cycles -> out_valid=0, count=0, out_data=0x5A, in_ready=1 after release.
REQ-035 Streaming: push 0x01, 0x02, 0x03 back-to-back with out_ready=1 -> out_valid high at cycles 3, 4, 5 carrying 0x01, 0x02, 0x03; count reaches 3 at most.
REQ-036 Backpressure: COLLAPSE=1, out_ready=0, offer 4 items -> 3 accepted, in_ready=0 on the 4th, count=3; then out_ready=1 -> outputs 1, 2, 3, 4 in order, count returns to 0.
REQ-037 Bubble: push A, idle 1 cycle, push B, out_ready=0 -> COLLAPSE=1: A and B in adjacent stages, count=2, in_ready=1; COLLAPSE=0: gap kept, whole pipe frozen once A is at the output.
REQ-038 Clear: full pipe, in_valid=1, out_ready=1, clr pulse -> that cycle in_ready=0 and one output transfer occurs; next cycle count=0, out_valid=0, out_data=0x5A.
REQ-039 Priority: rst and clr together mid-stream -> reset state as in REQ-030; rst alone with 2 items in flight -> those items never appear at the output.
